// File: rtl/aoi221_x2_sync.sv
// Registered, lane-parallel AOI221: zn = ~((c1&c2) | (b1&b2) | a), one cycle latency.
// Optional built-in self test enabled by defining AOI221_BIST_EN.
module aoi221_x2_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] b2,
  input  logic [WIDTH-1:0] c1,
  input  logic [WIDTH-1:0] c2,
`ifdef AOI221_BIST_EN
  input  logic             bist_start,
  output logic             bist_busy,
  output logic             bist_done,
  output logic             bist_pass,
  output logic [1:0]       bist_state,
`endif
  output logic [WIDTH-1:0] zn,
  output logic             out_valid
);

  // Handshake: in_valid qualifies the operands at a rising edge; there is no
  // ready, every valid beat is accepted and yields out_valid one cycle later.

  logic [WIDTH-1:0] r_zn;
  logic             r_out_valid;
  logic             w_load;
  logic             w_ov_nxt;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b1;
  logic [WIDTH-1:0] w_b2;
  logic [WIDTH-1:0] w_c1;
  logic [WIDTH-1:0] w_c2;

`ifdef AOI221_BIST_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } bist_state_t;

  // Bit p is the expected lane output for pattern p = {a,b1,b2,c1,c2}.
  localparam logic [31:0] GOLDEN = 32'h0000_0777;

  bist_state_t r_state;
  bist_state_t w_state_nxt;
  logic [4:0]  r_cnt;
  logic        r_chk;
  logic [4:0]  r_chk_pat;
  logic        r_fail;
  logic        r_done;
  logic        r_pass;
  logic        w_busy;
  logic        w_drive;
  logic        w_start;
  logic        w_mismatch;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bist_start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == 5'd31) w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy  = (r_state != S_IDLE);
    w_drive = (r_state == S_RUN);
    w_start = (r_state == S_IDLE) && bist_start;
  end

  // The registered result of the previous pattern is checked one cycle after load.
  assign w_mismatch = r_chk && (r_zn != {WIDTH{GOLDEN[r_chk_pat]}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= 5'd0;
      r_chk     <= 1'b0;
      r_chk_pat <= 5'd0;
      r_fail    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      r_chk     <= w_drive;
      r_chk_pat <= r_cnt;
      r_done    <= (r_state == S_FLUSH);
      if (w_start) begin
        r_cnt  <= 5'd0;
        r_fail <= 1'b0;
        r_pass <= 1'b0;
      end else begin
        if (w_drive)    r_cnt  <= r_cnt + 5'd1;
        if (w_mismatch) r_fail <= 1'b1;
        if (r_state == S_FLUSH) r_pass <= !(r_fail || w_mismatch);
      end
    end
  end

  always_comb begin
    w_a      = w_drive ? {WIDTH{r_cnt[4]}} : a;
    w_b1     = w_drive ? {WIDTH{r_cnt[3]}} : b1;
    w_b2     = w_drive ? {WIDTH{r_cnt[2]}} : b2;
    w_c1     = w_drive ? {WIDTH{r_cnt[1]}} : c1;
    w_c2     = w_drive ? {WIDTH{r_cnt[0]}} : c2;
    w_ov_nxt = in_valid && !w_busy;
    w_load   = w_drive || w_ov_nxt;
  end

  assign bist_busy  = w_busy;
  assign bist_done  = r_done;
  assign bist_pass  = r_pass;
  assign bist_state = r_state;
`else
  always_comb begin
    w_a      = a;
    w_b1     = b1;
    w_b2     = b2;
    w_c1     = c1;
    w_c2     = c2;
    w_ov_nxt = in_valid;
    w_load   = in_valid;
  end
`endif

  // Reset value all ones equals the function's output for all-zero operands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_zn        <= {WIDTH{1'b1}};
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_ov_nxt;
      if (w_load) r_zn <= ~((w_c1 & w_c2) | (w_b1 & w_b2) | w_a);
    end
  end

  assign zn        = r_zn;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_aoi221_x2_sync.sv
// Directed/random bench for aoi221_x2_sync (WIDTH=4) with a queue-based scoreboard.
// Covers the AOI221_BIST_EN build when that macro is defined.
module tb_aoi221_x2_sync;
  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a, b1, b2, c1, c2;
  logic [W-1:0] zn;
  logic         out_valid;
`ifdef AOI221_BIST_EN
  logic         bist_start;
  logic         bist_busy;
  logic         bist_done;
  logic         bist_pass;
  logic [1:0]   bist_state;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_zn;

  aoi221_x2_sync #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b1(b1), .b2(b2), .c1(c1), .c2(c2),
`ifdef AOI221_BIST_EN
    .bist_start(bist_start), .bist_busy(bist_busy), .bist_done(bist_done),
    .bist_pass(bist_pass), .bist_state(bist_state),
`endif
    .zn(zn), .out_valid(out_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane is 1 only for the nine listed {a,b1,b2,c1,c2} patterns.
  function automatic logic [W-1:0] model(input logic [W-1:0] ia, ib1, ib2, ic1, ic2);
    logic [W-1:0] r;
    logic [4:0]   p;
    for (int i = 0; i < W; i++) begin
      p = {ia[i], ib1[i], ib2[i], ic1[i], ic2[i]};
      r[i] = (p inside {5'd0, 5'd1, 5'd2, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10});
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver + scoreboard: drive one beat, then compare after the edge
  task automatic step(input logic v, input logic [W-1:0] ia, ib1, ib2, ic1, ic2);
    logic [W-1:0] e;
    in_valid = v; a = ia; b1 = ib1; b2 = ib2; c1 = ic1; c2 = ic2;
    if (v && rst_n) exp_q.push_back(model(ia, ib1, ib2, ic1, ic2));
    @(posedge clk); #1;
    if (!rst_n) begin
      chk("rst_zn", zn, {W{1'b1}});
      chk("rst_ov", {{(W-1){1'b0}}, out_valid}, '0);
      last_zn = {W{1'b1}};
    end else if (v) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("zn", zn, e);
        chk("ov", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, 1'b1});
        last_zn = e;
      end
    end else begin
      chk("hold_zn", zn, last_zn);
      chk("hold_ov", {{(W-1){1'b0}}, out_valid}, '0);
    end
  endtask

  initial begin
    logic [4:0] pv;
    rst_n = 1'b0; in_valid = 1'b0;
    a = '0; b1 = '0; b2 = '0; c1 = '0; c2 = '0;
    last_zn = {W{1'b1}};
`ifdef AOI221_BIST_EN
    bist_start = 1'b0;
`endif

    // reset with random inputs for two cycles
    repeat (2) step(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                    W'($urandom), W'($urandom), W'($urandom));
`ifdef AOI221_BIST_EN
    chk("rst_busy", {{(W-1){1'b0}}, bist_busy}, '0);
    chk("rst_pass", {{(W-1){1'b0}}, bist_pass}, '0);
`endif
    rst_n = 1'b1;
    repeat (2) step(1'b0, W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));

    // exhaustive sweep, pattern replicated on all lanes, back to back
    for (int p = 0; p < 32; p++) begin
      pv = 5'(p);
      step(1'b1, {W{pv[4]}}, {W{pv[3]}}, {W{pv[2]}}, {W{pv[1]}}, {W{pv[0]}});
    end

    // lane independence
    step(1'b1, 4'b0000, 4'b1100, 4'b1010, 4'b0011, 4'b0101);
    chk("lanes", zn, 4'b0110);

    // hold: zn=0, then three idle cycles with zero operands, then valid
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    repeat (3) step(1'b0, '0, '0, '0, '0, '0);
    chk("hold_zero", zn, 4'b0000);
    step(1'b1, '0, '0, '0, '0, '0);
    chk("after_hold", zn, 4'b1111);

    // random back-to-back and gapped traffic
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
           W'($urandom), W'($urandom), W'($urandom));

    // reset collides with a valid beat that would give zn=0
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst_n = 1'b0;
    step(1'b1, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111);
    rst_n = 1'b1;
    step(1'b0, '0, '0, '0, '0, '0);

`ifdef AOI221_BIST_EN
    begin
      int busy_cnt;
      int done_cnt;
      busy_cnt = 0;
      done_cnt = 0;
      in_valid = 1'b1; a = '1;
      bist_start = 1'b1;
      @(posedge clk); #1;
      bist_start = 1'b0;
      for (int c = 0; c < 45; c++) begin
        if (bist_busy) busy_cnt++;
        if (bist_done) done_cnt++;
        if (bist_busy) chk("bist_ov", {{(W-1){1'b0}}, out_valid}, '0);
        bist_start = (c == 10);
        if (bist_busy || c < 40) begin
          in_valid = bist_busy; @(posedge clk); #1;
        end
      end
      in_valid = 1'b0;
      chk("bist_busy_cycles", W'(busy_cnt), W'(33));
      chk("bist_done_pulses", W'(done_cnt), W'(1));
      chk("bist_pass", {{(W-1){1'b0}}, bist_pass}, {{(W-1){1'b0}}, 1'b1});
      chk("bist_idle", {{(W-1){1'b0}}, bist_busy}, '0);
      chk("bist_last_zn", zn, 4'b0000);
      last_zn = 4'b0000;
      step(1'b0, '0, '0, '0, '0, '0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aoi221_x2_sync.md
Name: aoi221_x2_sync

Overview:
- Registered, lane-parallel AND-OR-INVERT 2-2-1 cell: per lane ZN = NOT( (C1 AND C2) OR (B1 AND B2) OR A ).
- Drop-in synchronous wrapper for the X2-strength AOI221 standard-cell function.
- Used in datapath glue where a clocked, valid-qualified AOI221 result is required.

Parameters:
- WIDTH, 1, number of independent bitwise AOI221 lanes (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  qualifies a, b1, b2, c1, c2 this cycle
- a  input  WIDTH  single-input OR leg, per lane
- b1  input  WIDTH  first AND pair, input 1
- b2  input  WIDTH  first AND pair, input 2
- c1  input  WIDTH  second AND pair, input 1
- c2  input  WIDTH  second AND pair, input 2
- zn  output  WIDTH  registered AOI221 result
- out_valid  output  1  high for one cycle per accepted input

Behaviour:
- Reset is synchronous and active-low: rst_n sampled low at a rising clk edge sets zn = all ones and out_valid = 0.
  - The all-ones value matches the function's value for all-zero inputs.
- Lane function: zn[i] = ~((c1[i] & c2[i]) | (b1[i] & b2[i]) | a[i]).
  - Lanes are fully independent; there is no cross-lane logic.
- zn[i] = 1 only when a[i] = 0, {b1,b2} != 11 and {c1,c2} != 11.
  - This is 9 of the 32 input combinations per lane; the other 23 give 0.
- Latency: exactly 1 cycle. A value accepted with in_valid = 1 at edge N appears on zn, with out_valid = 1, after edge N.
- in_valid = 0 at an edge:
  - zn holds its previous value.
  - out_valid = 0.
- No backpressure. A new input is accepted every cycle with in_valid = 1; back-to-back inputs yield back-to-back results.
- Reset asserted in the same cycle as in_valid: reset wins, the input is discarded, and zn = all ones.
- X or Z on any input of a lane is not required to be filtered. The output for that lane is unspecified; other lanes are unaffected.
- All outputs are driven directly from flops, with no combinational path from input to output.

Optional Feature:
- Macro AOI221_BIST_EN.
- When defined, add these ports:
  - bist_start input 1
  - bist_busy output 1
  - bist_done output 1
  - bist_pass output 1
- A bist_start pulse while idle runs a 5-bit counter 0..31 with bit order {A,B1,B2,C1,C2}, MSB = A.
  - Each pattern is replicated to all lanes and driven through the same datapath register.
  - Each registered zn is compared against an independent golden truth table.
- Timing:
  - bist_busy is high for 33 cycles: 32 patterns plus 1 pipeline flush.
  - in_valid is ignored and out_valid stays 0 while busy.
  - bist_done pulses for 1 cycle at the end.
- bist_pass is sticky until the next bist_start; it is 1 only if all 32 comparisons matched on all lanes.
- bist_start while busy is ignored.
- Reset clears the counter, bist_busy, bist_done and bist_pass.
- When not defined, none of these ports or logic exist.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with random inputs -> zn = all ones, out_valid = 0. Release -> outputs unchanged until the first in_valid.
- Exhaustive sweep, WIDTH = 1: apply patterns 00000..11111 ({A,B1,B2,C1,C2}) with in_valid = 1 -> next-cycle zn = 1 exactly for patterns 00000, 00001, 00010, 00100, 00101, 00110, 01000, 01001, 01010; 0 for all others.
- Lane independence, WIDTH = 4: a = 0000, b1 = 1100, b2 = 1010, c1 = 0011, c2 = 0101 -> zn = 0110.
- Hold and valid: a result of zn = 0, then in_valid = 0 for 3 cycles with inputs changed to all zeros -> zn stays 0 and out_valid = 0. Then in_valid = 1 -> zn = 1 one cycle later with out_valid = 1.
- Reset collision: rst_n = 0 and in_valid = 1 with a = 1 on the same edge -> zn = all ones and out_valid = 0.
- With AOI221_BIST_EN: pulse bist_start -> bist_busy high for 33 cycles, bist_done pulses once, bist_pass = 1. A bist_start pulse mid-run has no effect.
